game_display_scheduler: RTL and testbench

- Controller that shares the single seven-segment display and the seven game buttons between the four games (counter, dice, higher/lower, binary quiz).
- Sequences a timed game-number banner after each switch, then grants buttons and display to the selected game.
- Enters an attract mode after an idle period.
- Sits between the button pulse modules and the game instances/sevenseg_driver, replacing the bare game_select_reg and the display multiplexer.

---
 rtl/game_display_scheduler.sv | 137 +++++++++++++
 tb/tb_game_display_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/game_display_scheduler.sv
// Shares the seven-segment display and game buttons between four games: a timed
// game-number banner after each switch, then a play grant, and an attract rotation after idling.
module game_display_scheduler #(
  parameter int BANNER_CYCLES  = 4,
  parameter int IDLE_CYCLES    = 16,
  parameter int ATTRACT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        switch_pulse,
  input  logic [6:0]  btn_pulse,
  input  logic [15:0] game_value,
  output logic [1:0]  game_sel,
  output logic [3:0]  game_en,
  output logic [6:0]  btn_out,
  output logic [3:0]  display_value,
  output logic [1:0]  sched_state
);

  localparam int BW = (BANNER_CYCLES  > 1) ? $clog2(BANNER_CYCLES)  : 1;
  localparam int IW = (IDLE_CYCLES    > 1) ? $clog2(IDLE_CYCLES)    : 1;
  localparam int AW = (ATTRACT_CYCLES > 1) ? $clog2(ATTRACT_CYCLES) : 1;
  localparam logic [BW-1:0] BAN_LAST  = BW'(BANNER_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [AW-1:0] ATT_LAST  = AW'(ATTRACT_CYCLES - 1);

  typedef enum logic [1:0] {
    BANNER  = 2'b00,
    PLAY    = 2'b01,
    ATTRACT = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [BW-1:0]   ban_q, ban_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [1:0]      att_idx_q, att_idx_d;
  logic [AW-1:0]   att_tmr_q, att_tmr_d;
  logic            any_pulse;

  assign any_pulse = switch_pulse | (|btn_pulse);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BANNER;
      sel_q     <= 2'd0;
      ban_q     <= '0;
      idle_q    <= '0;
      att_idx_q <= 2'd0;
      att_tmr_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ban_q     <= ban_d;
      idle_q    <= idle_d;
      att_idx_q <= att_idx_d;
      att_tmr_q <= att_tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ban_d     = ban_q;
    idle_d    = idle_q;
    att_idx_d = att_idx_q;
    att_tmr_d = att_tmr_q;
    case (state_q)
      BANNER: begin
        if (switch_pulse) begin
          sel_d = sel_q + 2'd1;
          ban_d = '0;
        end else if (ban_q == BAN_LAST) begin
          state_d = PLAY;
          idle_d  = '0;
        end else begin
          ban_d = ban_q + 1'b1;
        end
      end
      PLAY: begin
        if (switch_pulse) begin
          sel_d   = sel_q + 2'd1;
          state_d = BANNER;
          ban_d   = '0;
        end else if (any_pulse) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          state_d   = ATTRACT;
          att_idx_d = sel_q;
          att_tmr_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ATTRACT: begin
        // The waking pulse is swallowed: no forward, no game increment.
        if (any_pulse) begin
          state_d = BANNER;
          ban_d   = '0;
        end else if (att_tmr_q == ATT_LAST) begin
          att_idx_d = att_idx_q + 2'd1;
          att_tmr_d = '0;
        end else begin
          att_tmr_d = att_tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = BANNER;
        ban_d   = '0;
      end
    endcase
  end

  // Outputs are forced to their reset values while rst_n is low, even before the first edge.
  always_comb begin
    display_value = 4'd0;
    game_en       = 4'b0000;
    btn_out       = 7'b0;
    sched_state   = 2'b00;
    if (rst_n) begin
      sched_state = state_q;
      case (state_q)
        BANNER:  display_value = {2'b00, sel_q};
        PLAY: begin
          display_value = game_value[{sel_q, 2'b00} +: 4];
          game_en       = 4'b0001 << sel_q;
          btn_out       = switch_pulse ? 7'b0 : btn_pulse;
        end
        ATTRACT: display_value = game_value[{att_idx_q, 2'b00} +: 4];
        default: display_value = 4'd0;
      endcase
    end
  end

  assign game_sel = sel_q;

endmodule

// File: tb/tb_game_display_scheduler.sv
// Directed bench for game_display_scheduler with default parameters (4/16/8).
module tb_game_display_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        switch_pulse;
  logic [6:0]  btn_pulse;
  logic [15:0] game_value;
  logic [1:0]  game_sel;
  logic [3:0]  game_en;
  logic [6:0]  btn_out;
  logic [3:0]  display_value;
  logic [1:0]  sched_state;

  int n_chk  = 0;
  int n_fail = 0;

  game_display_scheduler dut (
    .clk(clk), .rst_n(rst_n), .switch_pulse(switch_pulse), .btn_pulse(btn_pulse),
    .game_value(game_value), .game_sel(game_sel), .game_en(game_en), .btn_out(btn_out),
    .display_value(display_value), .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [1:0] sel,
                         input logic [3:0] en, input logic [3:0] disp, input logic [6:0] bo);
    chk({tag, "_state"}, 16'(sched_state), 16'(st));
    chk({tag, "_sel"},   16'(game_sel),    16'(sel));
    chk({tag, "_en"},    16'(game_en),     16'(en));
    chk({tag, "_disp"},  16'(display_value), 16'(disp));
    chk({tag, "_btn"},   16'(btn_out),     16'(bo));
  endtask

  // Switch from PLAY, then ride out the banner into PLAY on the new game.
  task automatic do_switch(input logic [1:0] nsel, input logic [3:0] pdisp);
    switch_pulse = 1'b1;
    #1 chk("sw_btn", 16'(btn_out), 16'h0);
    cyc();
    switch_pulse = 1'b0;
    chk_all("sw_ban0", 2'b00, nsel, 4'b0000, {2'b00, nsel}, 7'b0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk_all("sw_ban", 2'b00, nsel, 4'b0000, {2'b00, nsel}, 7'b0);
    end
    cyc();
    chk_all("sw_play", 2'b01, nsel, 4'b0001 << nsel, pdisp, 7'b0);
  endtask

  initial begin
    logic [3:0] att_exp [4];
    att_exp[0] = 4'd3; att_exp[1] = 4'd4; att_exp[2] = 4'd1; att_exp[3] = 4'd2;

    rst_n = 1'b0; switch_pulse = 1'b0; btn_pulse = 7'b0; game_value = 16'h4321;
    #1;
    chk("pre_edge_disp", 16'(display_value), 16'h0);
    chk("pre_edge_en",   16'(game_en),       16'h0);
    chk("pre_edge_state", 16'(sched_state),  16'h0);
    btn_pulse = 7'h7F;
    #1 chk("rst_btn_gate", 16'(btn_out), 16'h0);
    btn_pulse = 7'b0;
    cyc();
    chk_all("rst_hold1", 2'b00, 2'd0, 4'b0000, 4'd0, 7'b0);
    cyc();
    chk_all("rst_hold2", 2'b00, 2'd0, 4'b0000, 4'd0, 7'b0);

    // Banner cycles 1..4 after release, with a dropped button in cycle 3.
    rst_n = 1'b1;
    #1 chk_all("ban_c1", 2'b00, 2'd0, 4'b0000, 4'd0, 7'b0);
    for (int c = 2; c <= 4; c++) begin
      cyc();
      if (c == 3) btn_pulse = 7'b0000001;
      #1 chk_all("ban_c", 2'b00, 2'd0, 4'b0000, 4'd0, 7'b0);
      btn_pulse = 7'b0;
    end
    cyc();
    chk_all("play_c5", 2'b01, 2'd0, 4'b0001, 4'h1, 7'b0);

    // Zero-latency forward, then switch beats button.
    btn_pulse = 7'b0000001;
    #1 chk("fwd_btn", 16'(btn_out), 16'h01);
    cyc();
    btn_pulse = 7'b0000001; switch_pulse = 1'b1;
    #1 chk("sw_wins_btn", 16'(btn_out), 16'h0);
    cyc();
    btn_pulse = 7'b0; switch_pulse = 1'b0;
    chk_all("sw1_ban0", 2'b00, 2'd1, 4'b0000, 4'd1, 7'b0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk_all("sw1_ban", 2'b00, 2'd1, 4'b0000, 4'd1, 7'b0);
    end
    cyc();
    chk_all("sw1_play", 2'b01, 2'd1, 4'b0010, 4'h2, 7'b0);

    // Selection sequence continues 2, 3, 0.
    do_switch(2'd2, 4'h3);
    do_switch(2'd3, 4'h4);
    do_switch(2'd0, 4'h1);

    // A switch in banner cycle 2 restarts the banner with the new digit.
    switch_pulse = 1'b1;
    cyc();
    switch_pulse = 1'b0;
    chk_all("rs_ban_c1", 2'b00, 2'd1, 4'b0000, 4'd1, 7'b0);
    cyc();
    chk_all("rs_ban_c2", 2'b00, 2'd1, 4'b0000, 4'd1, 7'b0);
    switch_pulse = 1'b1;
    cyc();
    switch_pulse = 1'b0;
    chk_all("rs_new0", 2'b00, 2'd2, 4'b0000, 4'd2, 7'b0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk_all("rs_new", 2'b00, 2'd2, 4'b0000, 4'd2, 7'b0);
    end
    cyc();
    chk_all("rs_play", 2'b01, 2'd2, 4'b0100, 4'h3, 7'b0);

    // Idle for 16 PLAY cycles, then attract rotation 3,4,1,2.
    for (int i = 2; i <= 16; i++) begin
      cyc();
      chk("idle_state", 16'(sched_state), 16'h1);
    end
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        cyc();
        chk_all("att", 2'b10, 2'd2, 4'b0000, att_exp[j], 7'b0);
      end
    end

    // Button bit 3 wakes to the banner with the same game.
    btn_pulse = 7'b0001000;
    #1 chk("wake_btn", 16'(btn_out), 16'h0);
    cyc();
    btn_pulse = 7'b0;
    chk_all("wake_ban0", 2'b00, 2'd2, 4'b0000, 4'd2, 7'b0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk_all("wake_ban", 2'b00, 2'd2, 4'b0000, 4'd2, 7'b0);
    end
    cyc();
    chk_all("wake_play", 2'b01, 2'd2, 4'b0100, 4'h3, 7'b0);

    // Reach ATTRACT on game 3, then reset for one cycle.
    do_switch(2'd3, 4'h4);
    for (int i = 2; i <= 17; i++) cyc();
    chk_all("att3", 2'b10, 2'd3, 4'b0000, 4'h4, 7'b0);
    rst_n = 1'b0;
    #1 chk("rst_att_disp", 16'(display_value), 16'h0);
    cyc();
    rst_n = 1'b1;
    #1 chk_all("post_rst", 2'b00, 2'd0, 4'b0000, 4'd0, 7'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
